mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage load/store unit: drives a request/ack RAM port and registers the MEM_WB payload.
// Optional MEM_MISALIGN_CHECK_EN: reject misaligned half/word accesses instead of aligning them.
module mem_access #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetIn,
  input  logic        validIn,
  input  logic [31:0] aluResultIn,
  input  logic [31:0] storeDataIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [2:0]  funct3In,
  input  logic        writeEnableIn,
  input  logic [4:0]  writeBackAddrIn,
  output logic        ramReq,
  output logic        ramWe,
  output logic [31:0] ramAddr,
  output logic [31:0] ramWdata,
  output logic [3:0]  ramStrb,
  input  logic        ramAck,
  input  logic [31:0] ramRdata,
  output logic        stallOut,
  output logic        select,
  output logic [31:0] dataFromALU,
  output logic [31:0] dataFromRam,
  output logic        writeEnableOut,
  output logic [4:0]  writeBackAddrOut,
  output logic        memError
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit CHECK_MISALIGN = 1'b1;
`else
  localparam bit CHECK_MISALIGN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic [XLEN-1:0]   addr_q, addr_nxt;
  logic [2:0]        f3_q, f3_nxt;
  logic [1:0]        off_q, off_nxt;
  logic              we_q, we_nxt;
  logic [RW-1:0]     wba_q, wba_nxt;

  logic              ram_req_nxt, ram_we_nxt;
  logic [XLEN-1:0]   ram_addr_nxt, ram_wdata_nxt;
  logic [3:0]        ram_strb_nxt;
  logic              select_nxt, we_out_nxt, mem_error_nxt;
  logic [XLEN-1:0]   alu_out_nxt, ram_out_nxt;
  logic [RW-1:0]     wba_out_nxt;

  logic              mem_op, misaligned;
  logic [1:0]        size, off_eff;
  logic [XLEN-1:0]   st_data, ld_shift, ld_data;
  logic [3:0]        st_strb;

  // Request decode: access size, effective byte offset, store lane replication.
  always_comb begin : decode
    mem_op     = memReadIn | memWriteIn;
    size       = funct3In[1:0];
    misaligned = ((size == 2'b01) && aluResultIn[0]) ||
                 (size[1] && (aluResultIn[1:0] != 2'b00));
    off_eff    = 2'b00;
    st_data    = storeDataIn;
    st_strb    = 4'b1111;
    case (size)
      2'b00: begin
        off_eff = aluResultIn[1:0];
        st_data = {4{storeDataIn[7:0]}};
        st_strb = 4'(4'b0001 << aluResultIn[1:0]);
      end
      2'b01: begin
        off_eff = {aluResultIn[1], 1'b0};
        st_data = {2{storeDataIn[15:0]}};
        st_strb = 4'(4'b0011 << {aluResultIn[1], 1'b0});
      end
      default: ;
    endcase
  end

  // Load return path: shift the addressed lane down, then sign/zero extend.
  always_comb begin : load_align
    ld_shift = ramRdata >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   ld_data = f3_q[2] ? {24'd0, ld_shift[7:0]}
                                 : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = f3_q[2] ? {16'd0, ld_shift[15:0]}
                                 : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  assign stallOut = resetIn &
                    ((state == ACCESS) || ((state == IDLE) && validIn && mem_op));

  always_ff @(posedge clk or negedge resetIn) begin : state_reg
    if (!resetIn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt     = state;
    cnt_nxt       = cnt;
    addr_nxt      = addr_q;
    f3_nxt        = f3_q;
    off_nxt       = off_q;
    we_nxt        = we_q;
    wba_nxt       = wba_q;
    ram_req_nxt   = 1'b0;
    ram_we_nxt    = ramWe;
    ram_addr_nxt  = ramAddr;
    ram_wdata_nxt = ramWdata;
    ram_strb_nxt  = ramStrb;
    select_nxt    = select;
    alu_out_nxt   = dataFromALU;
    ram_out_nxt   = dataFromRam;
    wba_out_nxt   = writeBackAddrOut;
    we_out_nxt    = 1'b0;
    mem_error_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (validIn && mem_op) begin
          addr_nxt      = aluResultIn;
          f3_nxt        = funct3In;
          off_nxt       = off_eff;
          we_nxt        = writeEnableIn;
          wba_nxt       = writeBackAddrIn;
          ram_we_nxt    = memWriteIn;
          ram_addr_nxt  = {aluResultIn[31:2], 2'b00};
          ram_wdata_nxt = st_data;
          ram_strb_nxt  = st_strb;
          if (CHECK_MISALIGN && misaligned) begin
            state_nxt     = DONE;
            mem_error_nxt = 1'b1;
            select_nxt    = 1'b0;
            alu_out_nxt   = aluResultIn;
            ram_out_nxt   = '0;
            wba_out_nxt   = writeBackAddrIn;
          end else begin
            state_nxt   = ACCESS;
            cnt_nxt     = '0;
            ram_req_nxt = 1'b1;
          end
        end else if (validIn) begin
          select_nxt  = 1'b1;
          alu_out_nxt = aluResultIn;
          ram_out_nxt = '0;
          we_out_nxt  = writeEnableIn;
          wba_out_nxt = writeBackAddrIn;
        end
      end
      ACCESS: begin
        if (ramAck) begin
          state_nxt   = DONE;
          select_nxt  = 1'b0;
          alu_out_nxt = addr_q;
          ram_out_nxt = ramWe ? '0 : ld_data;
          we_out_nxt  = we_q & ~ramWe;
          wba_out_nxt = wba_q;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_nxt     = DONE;
          mem_error_nxt = 1'b1;
          select_nxt    = 1'b0;
          alu_out_nxt   = addr_q;
          ram_out_nxt   = '0;
          wba_out_nxt   = wba_q;
        end else begin
          cnt_nxt     = cnt + CNT_W'(1);
          ram_req_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetIn) begin : data_reg
    if (!resetIn) begin
      addr_q           <= '0;
      f3_q             <= '0;
      off_q            <= '0;
      we_q             <= 1'b0;
      wba_q            <= '0;
      ramReq           <= 1'b0;
      ramWe            <= 1'b0;
      ramAddr          <= '0;
      ramWdata         <= '0;
      ramStrb          <= '0;
      select           <= 1'b0;
      dataFromALU      <= '0;
      dataFromRam      <= '0;
      writeEnableOut   <= 1'b0;
      writeBackAddrOut <= '0;
      memError         <= 1'b0;
    end else begin
      addr_q           <= addr_nxt;
      f3_q             <= f3_nxt;
      off_q            <= off_nxt;
      we_q             <= we_nxt;
      wba_q            <= wba_nxt;
      ramReq           <= ram_req_nxt;
      ramWe            <= ram_we_nxt;
      ramAddr          <= ram_addr_nxt;
      ramWdata         <= ram_wdata_nxt;
      ramStrb          <= ram_strb_nxt;
      select           <= select_nxt;
      dataFromALU      <= alu_out_nxt;
      dataFromRam      <= ram_out_nxt;
      writeEnableOut   <= we_out_nxt;
      writeBackAddrOut <= wba_out_nxt;
      memError         <= mem_error_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of single accesses plus reset/back-to-back sequences.
module tb_mem_access;

  localparam int unsigned ACK_TO = 16;

  logic        clk = 1'b0;
  logic        resetIn;
  logic        validIn;
  logic [31:0] aluResultIn;
  logic [31:0] storeDataIn;
  logic        memReadIn;
  logic        memWriteIn;
  logic [2:0]  funct3In;
  logic        writeEnableIn;
  logic [4:0]  writeBackAddrIn;
  logic        ramReq;
  logic        ramWe;
  logic [31:0] ramAddr;
  logic [31:0] ramWdata;
  logic [3:0]  ramStrb;
  logic        ramAck;
  logic [31:0] ramRdata;
  logic        stallOut;
  logic        select;
  logic [31:0] dataFromALU;
  logic [31:0] dataFromRam;
  logic        writeEnableOut;
  logic [4:0]  writeBackAddrOut;
  logic        memError;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk              (clk),
    .resetIn          (resetIn),
    .validIn          (validIn),
    .aluResultIn      (aluResultIn),
    .storeDataIn      (storeDataIn),
    .memReadIn        (memReadIn),
    .memWriteIn       (memWriteIn),
    .funct3In         (funct3In),
    .writeEnableIn    (writeEnableIn),
    .writeBackAddrIn  (writeBackAddrIn),
    .ramReq           (ramReq),
    .ramWe            (ramWe),
    .ramAddr          (ramAddr),
    .ramWdata         (ramWdata),
    .ramStrb          (ramStrb),
    .ramAck           (ramAck),
    .ramRdata         (ramRdata),
    .stallOut         (stallOut),
    .select           (select),
    .dataFromALU      (dataFromALU),
    .dataFromRam      (dataFromRam),
    .writeEnableOut   (writeEnableOut),
    .writeBackAddrOut (writeBackAddrOut),
    .memError         (memError)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          dly;      // ack in this ACCESS cycle; 0 = never
    logic [4:0]  wba;
    logic        we_in;
    logic        e_sel;
    logic [31:0] e_alu;
    logic [31:0] e_ram;
    logic        e_we;
    logic        e_err;
    int          e_stall;
    int          e_req;
    logic [31:0] e_raddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
  } vec_t;

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] sdata, input logic [31:0] rdata, input int dly,
    input logic [4:0] wba, input logic we_in,
    input logic e_sel, input logic [31:0] e_alu, input logic [31:0] e_ram,
    input logic e_we, input logic e_err, input int e_stall, input int e_req,
    input logic [31:0] e_raddr, input logic [31:0] e_wdata, input logic [3:0] e_strb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.dly = dly; v.wba = wba; v.we_in = we_in;
    v.e_sel = e_sel; v.e_alu = e_alu; v.e_ram = e_ram; v.e_we = e_we; v.e_err = e_err;
    v.e_stall = e_stall; v.e_req = e_req; v.e_raddr = e_raddr; v.e_wdata = e_wdata;
    v.e_strb = e_strb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    validIn = 1'b0; memReadIn = 1'b0; memWriteIn = 1'b0;
  endtask

  // Drive one instruction, service the RAM port, then check the registered result.
  task automatic run_vec(input int idx, input vec_t v);
    int   stall_n, req_n, cyc;
    logic done, unstable, got;
    logic [31:0] a0, w0;
    logic [3:0]  s0;
    logic        we0;
    stall_n = 0; req_n = 0; cyc = 0;
    done = 1'b0; unstable = 1'b0; got = 1'b0;
    a0 = '0; w0 = '0; s0 = '0; we0 = 1'b0;
    validIn = 1'b1; memReadIn = v.rd; memWriteIn = v.wr; funct3In = v.f3;
    aluResultIn = v.addr; storeDataIn = v.sdata;
    writeEnableIn = v.we_in; writeBackAddrIn = v.wba;
    #1;
    while (!done && cyc < 60) begin
      if (stallOut) stall_n++;
      if (ramReq) begin
        req_n++;
        if (!got) begin
          a0 = ramAddr; w0 = ramWdata; s0 = ramStrb; we0 = ramWe; got = 1'b1;
        end else if (ramAddr !== a0 || ramWdata !== w0 || ramStrb !== s0 || ramWe !== we0) begin
          unstable = 1'b1;
        end
        if (v.dly != 0 && req_n == v.dly) begin
          ramAck = 1'b1; ramRdata = v.rdata;
        end
      end
      @(negedge clk);
      ramAck = 1'b0; ramRdata = '0;
      #1;
      cyc++;
      if (!stallOut) done = 1'b1;
    end
    chk($sformatf("v%0d.done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d.select", idx), 32'(select), 32'(v.e_sel));
    chk($sformatf("v%0d.dataFromALU", idx), dataFromALU, v.e_alu);
    if (!v.wr) chk($sformatf("v%0d.dataFromRam", idx), dataFromRam, v.e_ram);
    chk($sformatf("v%0d.writeEnableOut", idx), 32'(writeEnableOut), 32'(v.e_we));
    if (v.e_we) chk($sformatf("v%0d.writeBackAddrOut", idx), 32'(writeBackAddrOut), 32'(v.wba));
    chk($sformatf("v%0d.memError", idx), 32'(memError), 32'(v.e_err));
    chk($sformatf("v%0d.stallCycles", idx), 32'(stall_n), 32'(v.e_stall));
    chk($sformatf("v%0d.reqCycles", idx), 32'(req_n), 32'(v.e_req));
    if (v.e_req > 0) begin
      chk($sformatf("v%0d.ramAddr", idx), a0, v.e_raddr);
      chk($sformatf("v%0d.ramWe", idx), 32'(we0), 32'(v.wr));
      chk($sformatf("v%0d.reqStable", idx), 32'(unstable), 32'd0);
      if (v.wr) begin
        chk($sformatf("v%0d.ramWdata", idx), w0, v.e_wdata);
        chk($sformatf("v%0d.ramStrb", idx), 32'(s0), 32'(v.e_strb));
      end
    end
    idle_inputs();
    @(negedge clk);
    #1;
    chk($sformatf("v%0d.errPulseEnd", idx), 32'(memError), 32'd0);
    chk($sformatf("v%0d.bubbleWe", idx), 32'(writeEnableOut), 32'd0);
    chk($sformatf("v%0d.reqIdle", idx), 32'(ramReq), 32'd0);
  endtask

  vec_t vecs[14];

  initial begin
    // ALU pass-through, loads of every width/sign, stores, timeout and the ack-on-last-cycle edge
    vecs[0]  = mk(0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 5'd5, 1,
                  1, 32'h0000_1234, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    vecs[1]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3, 5'd7, 1,
                  0, 32'h0000_0103, 32'hFFFF_FF80, 1, 0, 4, 3, 32'h0000_0100, 32'h0, 4'h0);
    vecs[2]  = mk(0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1, 5'd3, 1,
                  0, 32'h0000_0102, 32'h0, 0, 0, 2, 1, 32'h0000_0100, 32'hABCD_ABCD, 4'b1100);
    vecs[3]  = mk(1, 0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 0, 5'd9, 1,
                  0, 32'h0000_0200, 32'h0, 0, 1, 17, 16, 32'h0000_0200, 32'h0, 4'h0);
`ifdef MEM_MISALIGN_CHECK_EN
    vecs[4]  = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 2, 5'd10, 1,
                  0, 32'h0000_0101, 32'h0, 0, 1, 1, 0, 32'h0, 32'h0, 4'h0);
    vecs[12] = mk(0, 1, 3'b001, 32'h0000_0103, 32'h0000_1357, 32'h0, 1, 5'd17, 1,
                  0, 32'h0000_0103, 32'h0, 0, 1, 1, 0, 32'h0, 32'h0, 4'h0);
`else
    vecs[4]  = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 2, 5'd10, 1,
                  0, 32'h0000_0101, 32'h1122_3344, 1, 0, 3, 2, 32'h0000_0100, 32'h0, 4'h0);
    vecs[12] = mk(0, 1, 3'b001, 32'h0000_0103, 32'h0000_1357, 32'h0, 1, 5'd17, 1,
                  0, 32'h0000_0103, 32'h0, 0, 0, 2, 1, 32'h0000_0100, 32'h1357_1357, 4'b1100);
`endif
    vecs[5]  = mk(1, 0, 3'b100, 32'h0000_0101, 32'h0, 32'h1234_F0CD, 1, 5'd11, 1,
                  0, 32'h0000_0101, 32'h0000_00F0, 1, 0, 2, 1, 32'h0000_0100, 32'h0, 4'h0);
    vecs[6]  = mk(1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_1234, 2, 5'd12, 1,
                  0, 32'h0000_0102, 32'hFFFF_8001, 1, 0, 3, 2, 32'h0000_0100, 32'h0, 4'h0);
    vecs[7]  = mk(1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_9ABC, 1, 5'd13, 1,
                  0, 32'h0000_0100, 32'h0000_9ABC, 1, 0, 2, 1, 32'h0000_0100, 32'h0, 4'h0);
    vecs[8]  = mk(0, 1, 3'b000, 32'h0000_0203, 32'h1234_56A5, 32'h0, 2, 5'd14, 1,
                  0, 32'h0000_0203, 32'h0, 0, 0, 3, 2, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000);
    vecs[9]  = mk(0, 1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 1, 5'd2, 1,
                  0, 32'h0000_0300, 32'h0, 0, 0, 2, 1, 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111);
    vecs[10] = mk(0, 0, 3'b000, 32'hCAFE_0000, 32'h0, 32'h0, 0, 5'd31, 0,
                  1, 32'hCAFE_0000, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    vecs[11] = mk(1, 0, 3'b001, 32'h0000_0000, 32'h0, 32'h0000_7FFF, 16, 5'd15, 1,
                  0, 32'h0000_0000, 32'h0000_7FFF, 1, 0, 17, 16, 32'h0000_0000, 32'h0, 4'h0);
    vecs[13] = mk(1, 0, 3'b000, 32'h0000_0002, 32'h0, 32'h007F_0000, 1, 5'd16, 1,
                  0, 32'h0000_0002, 32'h0000_007F, 1, 0, 2, 1, 32'h0000_0000, 32'h0, 4'h0);

    // Reset held with a pending load and a stray ack: everything must read 0
    resetIn = 1'b0; validIn = 1'b1; memReadIn = 1'b1; memWriteIn = 1'b0;
    funct3In = 3'b010; aluResultIn = 32'h0000_0104; storeDataIn = 32'h5A5A_5A5A;
    writeEnableIn = 1'b1; writeBackAddrIn = 5'd1; ramAck = 1'b1; ramRdata = 32'hFFFF_FFFF;
    #12;
    chk("rst.ramReq", 32'(ramReq), 32'd0);
    chk("rst.stallOut", 32'(stallOut), 32'd0);
    chk("rst.memError", 32'(memError), 32'd0);
    chk("rst.select", 32'(select), 32'd0);
    chk("rst.dataFromALU", dataFromALU, 32'd0);
    chk("rst.dataFromRam", dataFromRam, 32'd0);
    chk("rst.writeEnableOut", 32'(writeEnableOut), 32'd0);
    chk("rst.writeBackAddrOut", 32'(writeBackAddrOut), 32'd0);
    chk("rst.ramAddr", ramAddr, 32'd0);
    chk("rst.ramWdata", ramWdata, 32'd0);
    chk("rst.ramStrb", 32'(ramStrb), 32'd0);
    chk("rst.ramWe", 32'(ramWe), 32'd0);
    @(negedge clk);
    idle_inputs(); ramAck = 1'b0; ramRdata = '0;
    resetIn = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Back-to-back: next instruction accepted in the IDLE cycle right after DONE
    validIn = 1'b1; memReadIn = 1'b1; funct3In = 3'b010; aluResultIn = 32'h0000_0500;
    writeEnableIn = 1'b1; writeBackAddrIn = 5'd4;
    @(negedge clk); #1;
    chk("b2b.ramReq", 32'(ramReq), 32'd1);
    ramAck = 1'b1; ramRdata = 32'h5555_AAAA;
    @(negedge clk); #1;
    ramAck = 1'b0; ramRdata = '0;
    chk("b2b.dataFromRam", dataFromRam, 32'h5555_AAAA);
    chk("b2b.weDone", 32'(writeEnableOut), 32'd1);
    chk("b2b.stallDone", 32'(stallOut), 32'd0);
    memReadIn = 1'b0; aluResultIn = 32'h0000_0777; writeBackAddrIn = 5'd6;
    @(negedge clk); #1;
    chk("b2b.weIdle", 32'(writeEnableOut), 32'd0);
    chk("b2b.stallIdle", 32'(stallOut), 32'd0);
    @(negedge clk); #1;
    chk("b2b.select", 32'(select), 32'd1);
    chk("b2b.dataFromALU", dataFromALU, 32'h0000_0777);
    chk("b2b.weAlu", 32'(writeEnableOut), 32'd1);
    chk("b2b.wbaAlu", 32'(writeBackAddrOut), 32'd6);
    idle_inputs();
    @(negedge clk); #1;

    // Reset asserted mid-ACCESS abandons the access with no writeback
    validIn = 1'b1; memReadIn = 1'b1; funct3In = 3'b010; aluResultIn = 32'h0000_0400;
    writeEnableIn = 1'b1; writeBackAddrIn = 5'd8;
    @(negedge clk); #1;
    chk("rstAcc.reqBefore", 32'(ramReq), 32'd1);
    @(negedge clk);
    #2 resetIn = 1'b0;
    #1;
    chk("rstAcc.ramReq", 32'(ramReq), 32'd0);
    chk("rstAcc.stallOut", 32'(stallOut), 32'd0);
    idle_inputs();
    @(negedge clk);
    resetIn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rstAcc.we%0d", c), 32'(writeEnableOut), 32'd0);
      chk($sformatf("rstAcc.req%0d", c), 32'(ramReq), 32'd0);
      chk($sformatf("rstAcc.err%0d", c), 32'(memError), 32'd0);
    end

    // Stray ack while IDLE is ignored
    ramAck = 1'b1; ramRdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk($sformatf("ackIdle.req%0d", c), 32'(ramReq), 32'd0);
      chk($sformatf("ackIdle.ram%0d", c), dataFromRam, 32'd0);
      chk($sformatf("ackIdle.we%0d", c), 32'(writeEnableOut), 32'd0);
    end
    ramAck = 1'b0; ramRdata = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
